// File: rtl/dfe_cfg_sequencer.sv
// Config-bus programmer for the DFE filter array: streams coefficient words onto the
// master config bus section by section, then optionally reads them back and compares checksums.
module dfe_cfg_sequencer #(
  parameter int COEFF_WIDTH = 20,
  parameter int PDATA_WIDTH = 32,
  parameter int ADDR_WIDTH  = 8,
  parameter int COMP        = 4,
  parameter int N_TAP       = 146,
  parameter int NUM_DENUM   = 5,
  parameter int XFER_GAP    = 2,
  parameter int RD_LAT      = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [3:0]             sect_en,
  input  logic                   verify_en,
  input  logic                   cfg_valid,
  output logic                   cfg_ready,
  input  logic [COEFF_WIDTH-1:0] cfg_data,
  output logic                   MTRANS,
  output logic                   MWRITE,
  output logic [COMP-1:0]        MSELx,
  output logic [ADDR_WIDTH-1:0]  MADDR,
  output logic [COEFF_WIDTH-1:0] MWDATA,
  input  logic [PDATA_WIDTH-1:0] MRDATA,
  output logic                   busy,
  output logic                   done,
  output logic                   err,
  output logic [1:0]             cur_sect
);

  localparam int RD_GAP = (RD_LAT > XFER_GAP) ? RD_LAT : XFER_GAP;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    WR     = 3'd1,
    VERIFY = 3'd2,
    DONE   = 3'd3,
    ERR    = 3'd4
  } state_t;

  state_t                 state_reg, state_next;
  logic [3:0]             sect_en_reg;
  logic                   verify_reg;
  logic [1:0]             first_sect_reg;
  logic [1:0]             cur_sect_reg;
  logic [ADDR_WIDTH-1:0]  addr_reg;
  logic                   walk_end_reg;
  logic [3:0]             gap_reg;
  logic [2:0]             lat_reg;
  logic                   pend_reg;
  logic [COEFF_WIDTH-1:0] wr_sum_reg, rd_sum_reg;
  logic                   err_reg;
  logic                   mtrans_reg, mwrite_reg;
  logic [COMP-1:0]        msel_reg;
  logic [ADDR_WIDTH-1:0]  maddr_reg;
  logic [COEFF_WIDTH-1:0] mwdata_reg;

  logic                   ready_c, wr_fire, rd_issue, rd_sample, step, walk_last;
  logic [2:0]             first_in, next_hit;
  logic [COMP-1:0]        sel_c;
  logic [COEFF_WIDTH-1:0] wdata_c;

  // Lowest enabled section index >= from; bit 2 flags that one exists.
  function automatic logic [2:0] find_sect(input logic [3:0] en, input logic [2:0] from);
    logic [2:0] r;
    r = 3'b000;
    for (int i = 3; i >= 0; i--) begin
      if (en[i] && (3'(i) >= from)) r = {1'b1, 2'(i)};
    end
    return r;
  endfunction

  function automatic logic [ADDR_WIDTH-1:0] sect_last(input logic [1:0] s);
    case (s)
      2'd0:       return ADDR_WIDTH'(N_TAP - 1);
      2'd1, 2'd2: return ADDR_WIDTH'(NUM_DENUM - 1);
      default:    return ADDR_WIDTH'(1);
    endcase
  endfunction

  genvar gi;
  generate
    for (gi = 0; gi < COMP; gi++) begin : g_sel
      assign sel_c[gi] = (gi < 4) && (int'(cur_sect_reg) == gi);
    end
  endgenerate

  // Only the low COEFF_WIDTH bits of read data participate in the checksum.
  generate
    if (PDATA_WIDTH > COEFF_WIDTH) begin : g_rd_hi
      logic unused_rdata_hi;
      assign unused_rdata_hi = ^MRDATA[PDATA_WIDTH-1:COEFF_WIDTH];
    end
  endgenerate

  assign first_in  = find_sect(sect_en, 3'd0);
  assign next_hit  = find_sect(sect_en_reg, {1'b0, cur_sect_reg} + 3'd1);
  assign walk_last = (addr_reg == sect_last(cur_sect_reg));
  // CIC R and CTRL registers only hold 5 bits.
  assign wdata_c   = (cur_sect_reg == 2'd3) ? COEFF_WIDTH'(cfg_data[4:0]) : cfg_data;

  always_comb begin
    state_next = state_reg;
    ready_c    = 1'b0;
    rd_issue   = 1'b0;
    rd_sample  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) state_next = first_in[2] ? WR : DONE;
      end
      WR: begin
        ready_c = !walk_end_reg && (gap_reg == 4'd0) && !mtrans_reg;
        if (walk_end_reg && (gap_reg == 4'd0) && !mtrans_reg)
          state_next = verify_reg ? VERIFY : DONE;
      end
      VERIFY: begin
        rd_sample = pend_reg && (lat_reg == 3'd0);
        rd_issue  = !walk_end_reg && (gap_reg == 4'd0) && !mtrans_reg &&
                    (!pend_reg || (lat_reg == 3'd0));
        if (walk_end_reg && !pend_reg)
          state_next = (rd_sum_reg == wr_sum_reg) ? DONE : ERR;
      end
      DONE:    state_next = IDLE;
      ERR:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign wr_fire = ready_c && cfg_valid;
  assign step    = wr_fire || rd_issue;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      sect_en_reg    <= 4'd0;
      verify_reg     <= 1'b0;
      first_sect_reg <= 2'd0;
      cur_sect_reg   <= 2'd0;
      addr_reg       <= '0;
      walk_end_reg   <= 1'b0;
      gap_reg        <= 4'd0;
      lat_reg        <= 3'd0;
      pend_reg       <= 1'b0;
      wr_sum_reg     <= '0;
      rd_sum_reg     <= '0;
      err_reg        <= 1'b0;
      mtrans_reg     <= 1'b0;
      mwrite_reg     <= 1'b0;
      msel_reg       <= '0;
      maddr_reg      <= '0;
      mwdata_reg     <= '0;
    end else begin
      state_reg  <= state_next;
      mtrans_reg <= 1'b0;

      if (wr_fire)             gap_reg <= 4'(XFER_GAP);
      else if (rd_issue)       gap_reg <= 4'(RD_GAP);
      else if (gap_reg != 4'd0) gap_reg <= gap_reg - 4'd1;

      if (rd_issue)             lat_reg <= 3'(RD_LAT);
      else if (lat_reg != 3'd0) lat_reg <= lat_reg - 3'd1;

      if (rd_issue)       pend_reg <= 1'b1;
      else if (rd_sample) pend_reg <= 1'b0;

      if (state_reg == IDLE && start) begin
        sect_en_reg    <= sect_en;
        verify_reg     <= verify_en;
        err_reg        <= 1'b0;
        wr_sum_reg     <= '0;
        rd_sum_reg     <= '0;
        first_sect_reg <= first_in[1:0];
        cur_sect_reg   <= first_in[1:0];
        addr_reg       <= '0;
        walk_end_reg   <= 1'b0;
      end

      if (wr_fire) begin
        mtrans_reg <= 1'b1;
        mwrite_reg <= 1'b1;
        msel_reg   <= sel_c;
        maddr_reg  <= addr_reg;
        mwdata_reg <= wdata_c;
        wr_sum_reg <= wr_sum_reg + wdata_c;
      end

      if (rd_issue) begin
        mtrans_reg <= 1'b1;
        mwrite_reg <= 1'b0;
        msel_reg   <= sel_c;
        maddr_reg  <= addr_reg;
      end

      if (rd_sample) rd_sum_reg <= rd_sum_reg + MRDATA[COEFF_WIDTH-1:0];

      // Shared walk over enabled sections for both write and readback passes.
      if (step) begin
        if (walk_last) begin
          addr_reg <= '0;
          if (next_hit[2]) cur_sect_reg <= next_hit[1:0];
          else             walk_end_reg <= 1'b1;
        end else begin
          addr_reg <= addr_reg + ADDR_WIDTH'(1);
        end
      end

      if (state_reg == WR && state_next == VERIFY) begin
        cur_sect_reg <= first_sect_reg;
        addr_reg     <= '0;
        walk_end_reg <= 1'b0;
      end

      if (state_next == ERR) err_reg <= 1'b1;
    end
  end

  assign cfg_ready = ready_c;
  assign MTRANS    = mtrans_reg;
  assign MWRITE    = mwrite_reg;
  assign MSELx     = msel_reg;
  assign MADDR     = maddr_reg;
  assign MWDATA    = mwdata_reg;
  assign busy      = (state_reg == WR) || (state_reg == VERIFY) || (state_reg == DONE);
  assign done      = (state_reg == DONE);
  assign err       = err_reg;
  assign cur_sect  = cur_sect_reg;

endmodule

// File: tb/tb_dfe_cfg_sequencer.sv
// Scoreboard bench for dfe_cfg_sequencer: expected bus transfers are queued as words are
// handed over and checked as strobes appear; a small echo memory answers readbacks.
module tb_dfe_cfg_sequencer;

  localparam int CW = 20;
  localparam int PW = 32;
  localparam int AW = 8;
  localparam int XG = 2;
  localparam int RL = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [3:0]    sect_en = 4'd0;
  logic          verify_en = 1'b0;
  logic          cfg_valid = 1'b0;
  logic          cfg_ready;
  logic [CW-1:0] cfg_data = '0;
  logic          MTRANS, MWRITE;
  logic [3:0]    MSELx;
  logic [AW-1:0] MADDR;
  logic [CW-1:0] MWDATA;
  logic [PW-1:0] MRDATA = 32'hDEADBEEF;
  logic          busy, done, err;
  logic [1:0]    cur_sect;

  always #5 clk = ~clk;

  dfe_cfg_sequencer #(
    .COEFF_WIDTH(CW), .PDATA_WIDTH(PW), .ADDR_WIDTH(AW), .COMP(4),
    .N_TAP(146), .NUM_DENUM(5), .XFER_GAP(XG), .RD_LAT(RL)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .sect_en(sect_en), .verify_en(verify_en),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_data(cfg_data),
    .MTRANS(MTRANS), .MWRITE(MWRITE), .MSELx(MSELx), .MADDR(MADDR), .MWDATA(MWDATA),
    .MRDATA(MRDATA), .busy(busy), .done(done), .err(err), .cur_sect(cur_sect)
  );

  typedef struct {
    bit          wr;
    logic [3:0]  sel;
    logic [7:0]  addr;
    logic [19:0] data;
  } xfer_t;

  xfer_t       exp_q[$];
  int          strobe_cyc[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          strobes = 0;
  int          done_cnt = 0;
  bit          rec_cyc = 1'b0;
  bit          corrupt = 1'b0;
  logic        prev_mtrans = 1'b0;
  logic [19:0] mem [0:3][0:255];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int sel2idx(input logic [3:0] s);
    int r;
    r = 0;
    for (int i = 0; i < 4; i++) if (s[i]) r = i;
    return r;
  endfunction

  function automatic int sect_size(input int s);
    if (s == 0) return 146;
    if (s == 3) return 2;
    return 5;
  endfunction

  task automatic drive_rd(input logic [19:0] v);
    repeat (RL) @(posedge clk);
    #1 MRDATA = {12'hA5C, v};
    @(posedge clk);
    #1 MRDATA = 32'hDEADBEEF;
  endtask

  // Bus monitor: pops the scoreboard on every strobe, keeps the echo memory.
  always @(negedge clk) begin
    xfer_t       e;
    logic [19:0] val;
    int          idx;
    if (done === 1'b1) done_cnt++;
    if (MTRANS === 1'b1) begin
      strobes++;
      if (rec_cyc) strobe_cyc.push_back(cyc);
      checks++;
      if (prev_mtrans === 1'b1) begin
        errors++;
        $display("FAIL back_to_back_strobe at cycle %0d", cyc);
      end
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_strobe wr=%b sel=%b addr=%0d", MWRITE, MSELx, MADDR);
      end else begin
        e = exp_q.pop_front();
        checks++;
        if (MWRITE !== e.wr || MSELx !== e.sel || MADDR !== e.addr || (e.wr && MWDATA !== e.data)) begin
          errors++;
          $display("FAIL bus_xfer got wr=%b sel=%b addr=%0d data=%h expected wr=%b sel=%b addr=%0d data=%h",
                   MWRITE, MSELx, MADDR, MWDATA, e.wr, e.sel, e.addr, e.data);
        end
      end
      idx = sel2idx(MSELx);
      if (MWRITE === 1'b1) begin
        mem[idx][MADDR] = MWDATA;
      end else begin
        val = mem[idx][MADDR];
        if (corrupt && MSELx == 4'b1000 && MADDR == 8'd0) val = 20'd4;
        fork
          begin
            automatic logic [19:0] v = val;
            drive_rd(v);
          end
        join_none
      end
      $display("xfer wr=%b sel=%b addr=%0d data=%h", MWRITE, MSELx, MADDR, MWDATA);
    end
    prev_mtrans = MTRANS;
  end

  task automatic pulse_start(input logic [3:0] en, input bit ver);
    @(posedge clk);
    #1 sect_en = en; verify_en = ver; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic send(input logic [19:0] d, input logic [3:0] sel, input logic [7:0] addr, input bit hold);
    xfer_t e;
    bit    got;
    got = 1'b0;
    cfg_data  = d;
    cfg_valid = 1'b1;
    for (int n = 0; n < 200 && !got; n++) begin
      @(negedge clk);
      got = (cfg_ready === 1'b1);
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL send_timeout ready=%b required 1 (sel=%b addr=%0d)", cfg_ready, sel, addr);
      cfg_valid = 1'b0;
      return;
    end
    @(posedge clk);
    e.wr   = 1'b1;
    e.sel  = sel;
    e.addr = addr;
    e.data = (sel == 4'b1000) ? {15'd0, d[4:0]} : d;
    exp_q.push_back(e);
    #1 if (!hold) cfg_valid = 1'b0;
  endtask

  task automatic push_read(input logic [3:0] sel, input logic [7:0] addr);
    xfer_t e;
    e.wr = 1'b0; e.sel = sel; e.addr = addr; e.data = '0;
    exp_q.push_back(e);
  endtask

  task automatic wait_idle(input string name);
    bit idle;
    idle = 1'b0;
    for (int n = 0; n < 3000 && !idle; n++) begin
      @(negedge clk);
      idle = (busy === 1'b0);
    end
    if (!idle) begin
      checks++;
      errors++;
      $display("FAIL %s_idle_timeout busy=%b required 0", name, busy);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({cfg_ready, MTRANS, MWRITE, busy, done, err} !== 6'b0 || MSELx !== 4'd0 ||
        MADDR !== 8'd0 || MWDATA !== 20'd0 || cur_sect !== 2'd0) begin
      errors++;
      $display("FAIL reset_outputs rdy=%b mt=%b mw=%b busy=%b done=%b err=%b sel=%b addr=%0d data=%h sect=%0d required all 0",
               cfg_ready, MTRANS, MWRITE, busy, done, err, MSELx, MADDR, MWDATA, cur_sect);
    end
    @(posedge clk); #1 rst = 1'b0;
    $display("test_reset done");
  endtask

  task automatic test_rst_mid_fd();
    int s0;
    pulse_start(4'b0001, 1'b0);
    for (int i = 0; i < 10; i++) send(20'($urandom), 4'b0001, 8'(i), 1'b1);
    cfg_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (MTRANS !== 1'b0 || busy !== 1'b0 || cur_sect !== 2'd0) begin
      errors++;
      $display("FAIL rst_abort mt=%b busy=%b sect=%0d required 0 0 0", MTRANS, busy, cur_sect);
    end
    checks++;
    if (MSELx !== 4'd0 || MADDR !== 8'd0 || MWDATA !== 20'd0 || cfg_ready !== 1'b0) begin
      errors++;
      $display("FAIL rst_bus_clear sel=%b addr=%0d data=%h rdy=%b required 0", MSELx, MADDR, MWDATA, cfg_ready);
    end
    @(posedge clk); #1 rst = 1'b0;
    s0 = strobes;
    repeat (10) @(posedge clk);
    #1;
    checks++;
    if (strobes != s0 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL rst_no_strobe strobes=%0d pending=%0d required %0d 0", strobes, exp_q.size(), s0);
    end
    exp_q.delete();
    $display("test_rst_mid_fd done");
  endtask

  task automatic test_all_sections();
    int s0, d0, bad;
    logic [19:0] d;
    s0 = strobes; d0 = done_cnt;
    strobe_cyc.delete();
    rec_cyc = 1'b1;
    pulse_start(4'b1111, 1'b0);
    for (int s = 0; s < 4; s++) begin
      for (int a = 0; a < sect_size(s); a++) begin
        d = (s == 3) ? 20'($urandom_range(0, 31)) : 20'($urandom);
        send(d, 4'(1 << s), 8'(a), 1'b1);
      end
    end
    cfg_valid = 1'b0;
    wait_idle("all_sections");
    rec_cyc = 1'b0;
    checks++;
    if (strobes - s0 != 158) begin
      errors++;
      $display("FAIL all_strobe_count got %0d required 158", strobes - s0);
    end
    checks++;
    if (done_cnt - d0 != 1 || err !== 1'b0) begin
      errors++;
      $display("FAIL all_done pulses=%0d err=%b required 1 0", done_cnt - d0, err);
    end
    bad = 0;
    for (int i = 1; i < strobe_cyc.size(); i++)
      if (strobe_cyc[i] - strobe_cyc[i-1] != XG + 1) bad++;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL all_spacing bad_gaps=%0d required 0", bad);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL all_pending got %0d required 0", exp_q.size());
    end
    $display("test_all_sections done");
  endtask

  task automatic test_valid_toggle();
    int s0, d0;
    s0 = strobes; d0 = done_cnt;
    pulse_start(4'b0100, 1'b0);
    for (int i = 1; i <= 5; i++) begin
      send(20'(i), 4'b0100, 8'(i - 1), 1'b0);
      repeat (3) @(posedge clk);
      #1;
    end
    wait_idle("toggle");
    checks++;
    if (strobes - s0 != 5 || done_cnt - d0 != 1 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL toggle_count strobes=%0d done=%0d pending=%0d required 5 1 0",
               strobes - s0, done_cnt - d0, exp_q.size());
    end
    $display("test_valid_toggle done");
  endtask

  task automatic test_verify(input bit bad_echo);
    int s0, d0;
    s0 = strobes; d0 = done_cnt;
    corrupt = bad_echo;
    pulse_start(4'b1000, 1'b1);
    send(20'd3, 4'b1000, 8'd0, 1'b1);
    send(20'h15, 4'b1000, 8'd1, 1'b0);
    push_read(4'b1000, 8'd0);
    push_read(4'b1000, 8'd1);
    wait_idle(bad_echo ? "verify_fail" : "verify_pass");
    checks++;
    if (strobes - s0 != 4 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL verify_strobes got %0d pending %0d required 4 0", strobes - s0, exp_q.size());
    end
    checks++;
    if (done_cnt - d0 != (bad_echo ? 0 : 1) || err !== bad_echo || busy !== 1'b0) begin
      errors++;
      $display("FAIL verify_result bad=%0d done=%0d err=%b busy=%b required %0d %b 0",
               bad_echo, done_cnt - d0, err, busy, bad_echo ? 0 : 1, bad_echo);
    end
    corrupt = 1'b0;
    $display("test_verify bad_echo=%0d done", bad_echo);
  endtask

  task automatic test_start_ignored();
    int s0, d0;
    d0 = done_cnt;
    pulse_start(4'b0100, 1'b0);
    checks++;
    if (err !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL start_clears_err err=%b busy=%b required 0 1", err, busy);
    end
    send(20'hFFFFF, 4'b0100, 8'd0, 1'b0);
    send(20'h80000, 4'b0100, 8'd1, 1'b0);
    pulse_start(4'b0000, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b1 || done_cnt != d0) begin
      errors++;
      $display("FAIL busy_start_ignored busy=%b done=%0d required 1 %0d", busy, done_cnt, d0);
    end
    for (int i = 2; i < 5; i++) send(20'(i * 7), 4'b0100, 8'(i), 1'b0);
    wait_idle("ignored");
    checks++;
    if (done_cnt - d0 != 1 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL ignored_finish done=%0d pending=%0d required 1 0", done_cnt - d0, exp_q.size());
    end
    $display("test_start_ignored done");
  endtask

  task automatic test_empty_sections();
    int s0;
    s0 = strobes;
    pulse_start(4'b0000, 1'b0);
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL empty_done done=%b busy=%b required 1 1", done, busy);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL empty_exit done=%b busy=%b required 0 0", done, busy);
    end
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (strobes != s0) begin
      errors++;
      $display("FAIL empty_no_strobe got %0d required %0d", strobes - s0, 0);
    end
    $display("test_empty_sections done");
  endtask

  initial begin
    test_reset();
    test_rst_mid_fd();
    test_all_sections();
    test_valid_toggle();
    test_verify(1'b0);
    test_verify(1'b1);
    test_start_ignored();
    test_empty_sections();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout cycles=%0d", cyc);
    $fatal(1, "timeout");
  end

endmodule
